ptcalc_mul_pipe: RTL and testbench
==================================

// Module: ptcalc_mul_pipe
// PURPOSE
//  Parametrised, pipelined signed multiplier for the pT-calculation datapath.
//  Computes a*b at full precision, then applies an optional arithmetic right
//  shift with round-half-up and saturation to the output width.
//  Carries a tag through the pipe and supports valid/ready backpressure, so it
//  can sit between ptcalc stages that stall.
//  With A_W=19, B_W=12, P_W=31, SHIFT=0 it gives the full 31-bit product.
// PARAMETERS
//  A_W        19  signed width of operand a
//  B_W        12  signed width of operand b
//  P_W        31  signed width of result p (P_W <= A_W+B_W)
//  SHIFT       0  arithmetic right shift applied to the product before saturation
//  NUM_STAGE   3  pipeline depth / latency in cycles (>=1)
//  TAG_W       8  width of the sideband tag carried alongside the data
// PORTS
//  ap_clk     in   1      clock, all logic on rising edge
//  ap_rst_n   in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept an input beat this cycle
//  in_a       in   A_W    signed operand a
//  in_b       in   B_W    signed operand b
//  in_tag     in   TAG_W  sideband tag, returned unchanged with the result
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts the result beat
//  out_p      out  P_W    signed rounded/saturated result
//  out_sat    out  1      result was clipped to +max or -min of P_W
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset: async assert clears every stage valid bit. out_valid=0, out_p=0,
//    out_sat=0, out_tag=0. in_ready=1 from the first edge after deassert.
//  - Pipe: NUM_STAGE register slots S1..SN, each holding a valid bit and payload.
//    SN drives the out_* ports directly.
//  - Advance: SN advances when it is empty or out_ready=1. Sk (k<N) advances
//    when S(k+1) is empty or advancing. in_ready = S1 empty or advancing.
//    Bubbles collapse. Throughput is 1 beat/cycle when out_ready=1.
//  - Transfer: an input beat transfers on in_valid & in_ready. An output beat
//    transfers on out_valid & out_ready. Data is never dropped or duplicated.
//    A stalled out_* stays stable until accepted.
//  - Latency: exactly NUM_STAGE cycles from input transfer to out_valid when
//    there is no backpressure.
//  - Arithmetic:
//      full = a*b, signed, width A_W+B_W, exact.
//      If SHIFT>0: r = (full + 2^(SHIFT-1)) >>> SHIFT. The rounding add is done
//        at A_W+B_W+1 bits so it cannot overflow. This is round half up:
//        -1.5 -> -1, -1.75 -> -2.
//      If SHIFT=0: r = full.
//      If r > 2^(P_W-1)-1: out_p = +max, out_sat=1.
//      If r < -2^(P_W-1): out_p = -min, out_sat=1.
//      Otherwise out_p = r[P_W-1:0], out_sat=0.
//  - Retiming: the multiply may be split across stages for DSP inference.
//    Rounding and saturation must resolve before SN is loaded. Only cycle
//    behaviour at the ports is fixed.
//  - Simultaneous accept + output: when SN is full, out_ready=1 and a new
//    beat enters S1, both happen in the same cycle. No bubble is inserted.
//  - Reset mid-operation: all in-flight beats are discarded and nothing is
//    emitted after reset. Payload registers need no reset except the
//    out_* drivers.
//  - in_* are ignored while in_ready=0. Upstream must hold them stable.
// TESTING
//  1 Reset: ap_rst_n=0 with in_valid=1 -> out_valid=0, out_p=0. Release ->
//    in_ready=1 on the next cycle.
//  2 Latency, defaults: a=-262144, b=-2048, out_ready=1 -> out_valid exactly
//    3 cycles later, out_p=536870912, out_sat=0, tag echoed.
//  3 Rounding, P_W=16, SHIFT=2: (3,3) -> 2; (-3,3) -> -2; (2,3) -> 2;
//    (-2,3) -> -1. out_sat=0 for all four.
//  4 Saturation, P_W=16, SHIFT=4: (1000,1000) -> 32767, sat=1;
//    (-1000,1000) -> -32768, sat=1; (100,100) -> 625, sat=0.
//  5 Backpressure: stream 10 beats with tags 0..9. Hold out_ready=0 for
//    5 cycles mid-stream -> in_ready=0 once all slots are full. Outputs are
//    in order, with no loss or duplication, and out_* stays stable while
//    stalled.
//  6 Full throughput and mid-stream reset: continuous in_valid with
//    out_ready=1 -> 1 result/cycle. Pulse ap_rst_n low mid-stream -> no
//    stale beat emitted afterwards.

Source files
------------

// File: rtl/ptcalc_mul_pipe.sv
// Pipelined signed multiplier with round-half-up shift, saturation, tag sideband
// and valid/ready backpressure. SN drives the out_* ports directly.
module ptcalc_mul_pipe #(
  parameter int A_W       = 19,
  parameter int B_W       = 12,
  parameter int P_W       = 31,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 3,
  parameter int TAG_W     = 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic        [TAG_W-1:0] in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [P_W-1:0]   out_p,
  output logic                    out_sat,
  output logic        [TAG_W-1:0] out_tag
);

  localparam int FULL_W = A_W + B_W;
  localparam logic signed [FULL_W:0] HALF = (FULL_W+1)'((2 ** SHIFT) / 2);
  localparam logic signed [FULL_W:0] MAXV = {{(FULL_W-P_W+2){1'b0}}, {(P_W-1){1'b1}}};
  localparam logic signed [FULL_W:0] MINV = ~MAXV;

  // Rounding add carried at FULL_W+1 bits so the +HALF can never wrap.
  function automatic logic signed [FULL_W:0] round_shift(input logic signed [FULL_W-1:0] full);
    logic signed [FULL_W:0] ext;
    ext = {full[FULL_W-1], full};
    return (ext + HALF) >>> SHIFT;
  endfunction

  // Returns {sat, p}.
  function automatic logic [P_W:0] saturate(input logic signed [FULL_W:0] r);
    logic [P_W:0] res;
    if (r > MAXV)      res = {1'b1, 1'b0, {(P_W-1){1'b1}}};
    else if (r < MINV) res = {1'b1, 1'b1, {(P_W-1){1'b0}}};
    else               res = {1'b0, r[P_W-1:0]};
    return res;
  endfunction

  logic [NUM_STAGE:1]       vld;
  logic [NUM_STAGE:1]       adv;
  logic signed [FULL_W-1:0] prod_p0;
  logic signed [FULL_W-1:0] last_prod;
  logic [TAG_W-1:0]         last_tag;
  logic                     last_vld;

  // Stage 0: full-precision product feeding S1 (or SN directly when depth is 1).
  assign prod_p0 = FULL_W'(in_a) * FULL_W'(in_b);

  // A slot advances when it is empty or the slot ahead of it advances.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = !vld[NUM_STAGE] || out_ready;
    adv[NUM_STAGE] = chain;
    for (int k = NUM_STAGE - 1; k >= 1; k--) begin
      chain  = !vld[k] || chain;
      adv[k] = chain;
    end
  end

  assign in_ready  = adv[1];
  assign out_valid = vld[NUM_STAGE];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld <= '0;
    end else begin
      if (adv[1]) vld[1] <= in_valid;
      for (int k = 2; k <= NUM_STAGE; k++)
        if (adv[k]) vld[k] <= vld[k-1];
    end
  end

  generate
    if (NUM_STAGE > 1) begin : g_mid
      logic signed [FULL_W-1:0] prod_q [1:NUM_STAGE-1];
      logic [TAG_W-1:0]         tag_q  [1:NUM_STAGE-1];

      // S1..S(N-1): product and tag move with their valid bits.
      always_ff @(posedge ap_clk) begin
        if (adv[1]) begin
          prod_q[1] <= prod_p0;
          tag_q[1]  <= in_tag;
        end
        for (int k = 2; k < NUM_STAGE; k++) begin
          if (adv[k]) begin
            prod_q[k] <= prod_q[k-1];
            tag_q[k]  <= tag_q[k-1];
          end
        end
      end

      assign last_prod = prod_q[NUM_STAGE-1];
      assign last_tag  = tag_q[NUM_STAGE-1];
      assign last_vld  = vld[NUM_STAGE-1];
    end else begin : g_direct
      assign last_prod = prod_p0;
      assign last_tag  = in_tag;
      assign last_vld  = in_valid;
    end
  endgenerate

  // SN: round and saturate resolve on the way in, so out_* are plain registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_p   <= '0;
      out_sat <= 1'b0;
      out_tag <= '0;
    end else if (adv[NUM_STAGE] && last_vld) begin
      {out_sat, out_p} <= saturate(round_shift(last_prod));
      out_tag          <= last_tag;
    end
  end

endmodule

// File: tb/tb_ptcalc_mul_pipe.sv
// Directed bench for ptcalc_mul_pipe: three instances (full product, SHIFT=2, SHIFT=4 at 16 bits).
module tb_ptcalc_mul_pipe;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic in_valid, out_ready;
  logic signed [18:0] in_a;
  logic signed [11:0] in_b;
  logic [7:0] in_tag;

  logic rdy0, rdy1, rdy2, vld0, vld1, vld2, sat0, sat1, sat2;
  logic signed [30:0] p0;
  logic signed [15:0] p1, p2;
  logic [7:0] tag0, tag1, tag2;

  always #5 ap_clk = ~ap_clk;

  ptcalc_mul_pipe dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(vld0), .out_ready(out_ready),
    .out_p(p0), .out_sat(sat0), .out_tag(tag0));

  ptcalc_mul_pipe #(.P_W(16), .SHIFT(2)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(vld1), .out_ready(out_ready),
    .out_p(p1), .out_sat(sat1), .out_tag(tag1));

  ptcalc_mul_pipe #(.P_W(16), .SHIFT(4)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(vld2), .out_ready(out_ready),
    .out_p(p2), .out_sat(sat2), .out_tag(tag2));

  typedef struct {
    logic signed [18:0] a;
    logic signed [11:0] b;
    logic [7:0]         tag;
    logic signed [30:0] e0;
    logic               s0;
    logic signed [15:0] e1;
    logic               s1;
    logic signed [15:0] e2;
    logic               s2;
  } vec_t;

  vec_t vecs [16];
  int   nv = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int a, input int b, input int e0, input int s0,
                         input int e1, input int s1, input int e2, input int s2);
    vecs[nv].a   = 19'(a);
    vecs[nv].b   = 12'(b);
    vecs[nv].tag = 8'(8'hA0 + nv);
    vecs[nv].e0  = 31'(e0);
    vecs[nv].s0  = 1'(s0);
    vecs[nv].e1  = 16'(e1);
    vecs[nv].s1  = 1'(s1);
    vecs[nv].e2  = 16'(e2);
    vecs[nv].s2  = 1'(s2);
    nv++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, got, stalled_prev, saw_block, in_fire;
    logic signed [30:0] held_p;
    logic [7:0] held_tag;

    //            a        b      full P_W=31     SHIFT=2 P_W=16  SHIFT=4 P_W=16
    add_vec(-262144, -2048,  536870912, 0,   32767, 1,   32767, 1);
    add_vec(      3,     3,          9, 0,       2, 0,       1, 0);
    add_vec(     -3,     3,         -9, 0,      -2, 0,      -1, 0);
    add_vec(      2,     3,          6, 0,       2, 0,       0, 0);
    add_vec(     -2,     3,         -6, 0,      -1, 0,       0, 0);
    add_vec(   1000,  1000,    1000000, 0,   32767, 1,   32767, 1);
    add_vec(  -1000,  1000,   -1000000, 0,  -32768, 1,  -32768, 1);
    add_vec(    100,   100,      10000, 0,    2500, 0,     625, 0);
    add_vec( 262143,  2047,  536606721, 0,   32767, 1,   32767, 1);
    add_vec(-262144,  2047, -536608768, 0,  -32768, 1,  -32768, 1);
    add_vec(     -8,     1,         -8, 0,      -2, 0,       0, 0);
    add_vec( 131069,     1,     131069, 0,   32767, 0,    8192, 0);
    add_vec( 131070,     1,     131070, 0,   32767, 1,    8192, 0);
    add_vec(-131074,     1,    -131074, 0,  -32768, 0,   -8192, 0);

    // Reset with in_valid asserted
    ap_rst_n  = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_a      = 19'sd5;
    in_b      = 12'sd7;
    in_tag    = 8'h55;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_out_valid", vld0, 0);
    check("rst_out_p", p0, 0);
    check("rst_out_sat", sat0, 0);
    check("rst_out_tag", tag0, 0);
    in_valid = 1'b0;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("rst_in_ready", rdy0, 1);
    check("rst_no_beat", vld0 | vld1 | vld2, 0);

    // Table of single beats: latency exactly 3 cycles, values for all three configs
    for (int i = 0; i < nv; i++) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      in_tag   = vecs[i].tag;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      @(posedge ap_clk);
      @(negedge ap_clk);
      check($sformatf("v%0d_early_valid", i), vld0, 0);
      @(posedge ap_clk);
      @(negedge ap_clk);
      check($sformatf("v%0d_valid", i), vld0 & vld1 & vld2, 1);
      check($sformatf("v%0d_p_full", i), p0, vecs[i].e0);
      check($sformatf("v%0d_sat_full", i), sat0, vecs[i].s0);
      check($sformatf("v%0d_p_sh2", i), p1, vecs[i].e1);
      check($sformatf("v%0d_sat_sh2", i), sat1, vecs[i].s1);
      check($sformatf("v%0d_p_sh4", i), p2, vecs[i].e2);
      check($sformatf("v%0d_sat_sh4", i), sat2, vecs[i].s2);
      check($sformatf("v%0d_tag", i), tag0, vecs[i].tag);
      @(posedge ap_clk); #1;
    end
    @(negedge ap_clk);
    check("table_no_duplicate", vld0, 0);
    @(posedge ap_clk); #1;

    // Backpressure: 10 beats, out_ready low for 5 cycles mid-stream
    sent = 0; got = 0; stalled_prev = 0; saw_block = 0;
    held_p = '0; held_tag = '0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      out_ready = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
      in_valid  = (sent < 10);
      in_a      = 19'(sent + 1);
      in_b      = 12'sd2;
      in_tag    = 8'(sent);
      @(negedge ap_clk);
      in_fire = int'(in_valid & rdy0);
      if (vld0 && !out_ready) begin
        if (!rdy0) saw_block = 1;
        if (stalled_prev != 0) begin
          check("bp_stall_p_stable", p0, held_p);
          check("bp_stall_tag_stable", tag0, held_tag);
        end
        held_p = p0;
        held_tag = tag0;
        stalled_prev = 1;
      end else begin
        stalled_prev = 0;
      end
      if (vld0 && out_ready) begin
        check("bp_order_tag", tag0, 8'(got));
        check("bp_value", p0, 2 * (got + 1));
        got++;
      end
      @(posedge ap_clk); #1;
      if (in_fire != 0) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_all_received", got, 10);
    check("bp_all_sent", sent, 10);
    check("bp_in_ready_blocked", saw_block, 1);
    @(negedge ap_clk);
    check("bp_no_extra_beat", vld0, 0);
    @(posedge ap_clk); #1;

    // Full throughput, then reset mid-stream
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_a     = 19'(c + 1);
      in_b     = -12'sd3;
      in_tag   = 8'(8'h40 + c);
      @(negedge ap_clk);
      check("tp_in_ready", rdy0, 1);
      if (c >= 3) begin
        check("tp_valid", vld0, 1);
        check("tp_tag", tag0, 8'(8'h40 + c - 3));
        check("tp_p", p0, -3 * (c - 2));
      end
      @(posedge ap_clk); #1;
    end
    #1 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_valid_clear", vld0 | vld1 | vld2, 0);
    check("mid_rst_p_clear", p0, 0);
    in_valid = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      check("post_rst_no_stale", vld0 | vld1 | vld2, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
